// File: rtl/mac_cluster_pkg.sv
// Shared constants, mode encoding and lane-grouping helpers for the MAC cluster.
package mac_cluster_pkg;

    localparam int MAC_MIN_WIDTH  = 16;
    localparam int MAC_ACC_WIDTH  = 32;
    localparam int MAC_CONF_WIDTH = 3;
    localparam int MAC_LANES      = 4;
    localparam int MAC_CFG_WIDTH  = MAC_CONF_WIDTH + MAC_LANES * MAC_ACC_WIDTH;
    localparam int MAC_SUM_WIDTH  = MAC_LANES * MAC_ACC_WIDTH;

    // cfg field offsets
    localparam int CFG_MODE_LO = 0;
    localparam int CFG_ACC_EN  = 2;
    localparam int CFG_INIT_LO = 3;

    typedef enum logic [1:0] {
        MAC_SINGLE = 2'b00,
        MAC_DUAL   = 2'b01,
        MAC_QUAD   = 2'b10,
        MAC_RSVD   = 2'b11
    } mac_mode_e;

    // Partial product Ai*Bj contributes only when both lanes belong to the same fused group.
    function automatic logic keep_term(input mac_mode_e mode, input int i, input int j);
        case (mode)
            MAC_QUAD: return 1'b1;
            MAC_DUAL: return (i / 2) == (j / 2);
            default:  return i == j;
        endcase
    endfunction

    // True when 32-bit lane k is the least significant lane of its group.
    function automatic logic group_start(input mac_mode_e mode, input int k);
        case (mode)
            MAC_QUAD: return k == 0;
            MAC_DUAL: return (k == 0) || (k == 2);
            default:  return 1'b1;
        endcase
    endfunction

    // 128-bit add whose carry chain is broken at group boundaries; cin re-enters at each group start.
    function automatic logic [MAC_SUM_WIDTH-1:0] group_add(
        input logic [MAC_SUM_WIDTH-1:0] a,
        input logic [MAC_SUM_WIDTH-1:0] b,
        input mac_mode_e                mode,
        input logic                     cin
    );
        logic [MAC_SUM_WIDTH-1:0] r;
        logic [MAC_ACC_WIDTH:0]   s;
        logic                     c;
        r = '0;
        c = cin;
        for (int k = 0; k < MAC_LANES; k++) begin
            if (group_start(mode, k)) begin
                c = cin;
            end
            s = {1'b0, a[MAC_ACC_WIDTH*k +: MAC_ACC_WIDTH]}
              + {1'b0, b[MAC_ACC_WIDTH*k +: MAC_ACC_WIDTH]}
              + {{MAC_ACC_WIDTH{1'b0}}, c};
            r[MAC_ACC_WIDTH*k +: MAC_ACC_WIDTH] = s[MAC_ACC_WIDTH-1:0];
            c = s[MAC_ACC_WIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_cluster_mul16.sv
// Combinational 16x16 -> 32 unsigned multiplier; one instance per (Ai, Bj) pair.
module mac_mul16
    import mac_cluster_pkg::*;
(
    input  logic [MAC_MIN_WIDTH-1:0]   a,
    input  logic [MAC_MIN_WIDTH-1:0]   b,
    output logic [2*MAC_MIN_WIDTH-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mac_cluster.sv
// Four-lane reconfigurable multiply-accumulate tile, two-stage pipeline.
// Stage 1 registers the 16 mode-masked partial products plus cfg; stage 2 sums them
// and loads/accumulates into four 32-bit lanes fused per mode.
// Optional build macro: MAC_CLUSTER_SIGNED_EN (two's complement operands at group width).
module mac_cluster
    import mac_cluster_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [MAC_MIN_WIDTH-1:0] A0,
    input  logic [MAC_MIN_WIDTH-1:0] A1,
    input  logic [MAC_MIN_WIDTH-1:0] A2,
    input  logic [MAC_MIN_WIDTH-1:0] A3,
    input  logic [MAC_MIN_WIDTH-1:0] B0,
    input  logic [MAC_MIN_WIDTH-1:0] B1,
    input  logic [MAC_MIN_WIDTH-1:0] B2,
    input  logic [MAC_MIN_WIDTH-1:0] B3,
    input  logic [MAC_CFG_WIDTH-1:0] cfg,
    output logic [MAC_ACC_WIDTH-1:0] out0,
    output logic [MAC_ACC_WIDTH-1:0] out1,
    output logic [MAC_ACC_WIDTH-1:0] out2,
    output logic [MAC_ACC_WIDTH-1:0] out3
);

    localparam int NPP = MAC_LANES * MAC_LANES;

    logic [MAC_MIN_WIDTH-1:0]   a_lane [MAC_LANES];
    logic [MAC_MIN_WIDTH-1:0]   b_lane [MAC_LANES];
    logic [2*MAC_MIN_WIDTH-1:0] pp_raw [NPP];

    assign a_lane[0] = A0;
    assign a_lane[1] = A1;
    assign a_lane[2] = A2;
    assign a_lane[3] = A3;
    assign b_lane[0] = B0;
    assign b_lane[1] = B1;
    assign b_lane[2] = B2;
    assign b_lane[3] = B3;

    genvar gi, gj;
    generate
        for (gi = 0; gi < MAC_LANES; gi++) begin : g_a
            for (gj = 0; gj < MAC_LANES; gj++) begin : g_b
                mac_mul16 u_mul (
                    .a (a_lane[gi]),
                    .b (b_lane[gj]),
                    .p (pp_raw[gi*MAC_LANES + gj])
                );
            end
        end
    endgenerate

    // ---------------- stage 1 ----------------
    mac_mode_e                  mode_d, mode_q;
    logic                       acc_en_d, acc_en_q;
    logic [MAC_SUM_WIDTH-1:0]   init_d, init_q;
    logic                       valid_q;
    logic [2*MAC_MIN_WIDTH-1:0] pp_d [NPP];
    logic [2*MAC_MIN_WIDTH-1:0] pp_q [NPP];

    // Decode cfg and mask off partial products that cross group boundaries.
    always_comb begin
        mode_d   = mac_mode_e'(cfg[CFG_MODE_LO +: 2]);
        acc_en_d = cfg[CFG_ACC_EN];
        init_d   = cfg[CFG_INIT_LO +: MAC_SUM_WIDTH];
        for (int k = 0; k < NPP; k++) begin
            pp_d[k] = keep_term(mode_d, k / MAC_LANES, k % MAC_LANES) ? pp_raw[k] : '0;
        end
    end

`ifdef MAC_CLUSTER_SIGNED_EN
    logic [MAC_SUM_WIDTH-1:0] corr_d, corr_q;
    logic [63:0]              a64, b64;
    logic [31:0]              a32, b32;
    logic [15:0]              a16, b16;

    // Sign correction per group: (sA ? B : 0) + (sB ? A : 0), shifted up by the operand width.
    always_comb begin
        corr_d = '0;
        a64    = {A3, A2, A1, A0};
        b64    = {B3, B2, B1, B0};
        a32    = '0;
        b32    = '0;
        a16    = '0;
        b16    = '0;
        case (mode_d)
            MAC_QUAD: begin
                corr_d = {(a64[63] ? b64 : 64'd0) + (b64[63] ? a64 : 64'd0), 64'd0};
            end
            MAC_DUAL: begin
                for (int p = 0; p < 2; p++) begin
                    a32 = a64[32*p +: 32];
                    b32 = b64[32*p +: 32];
                    corr_d[64*p +: 64] = {(a32[31] ? b32 : 32'd0) + (b32[31] ? a32 : 32'd0), 32'd0};
                end
            end
            default: begin
                for (int l = 0; l < MAC_LANES; l++) begin
                    a16 = a_lane[l];
                    b16 = b_lane[l];
                    corr_d[32*l +: 32] = {(a16[15] ? b16 : 16'd0) + (b16[15] ? a16 : 16'd0), 16'd0};
                end
            end
        endcase
    end

    // Sign-correction register travels alongside the partial products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_q <= '0;
        end else if (en) begin
            corr_q <= corr_d;
        end
    end
`endif

    // Stage-1 pipeline register: partial products, cfg and a valid marker (cleared by reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MAC_SINGLE;
            acc_en_q <= 1'b0;
            init_q   <= '0;
            valid_q  <= 1'b0;
            for (int k = 0; k < NPP; k++) begin
                pp_q[k] <= '0;
            end
        end else if (en) begin
            mode_q   <= mode_d;
            acc_en_q <= acc_en_d;
            init_q   <= init_d;
            valid_q  <= 1'b1;
            for (int k = 0; k < NPP; k++) begin
                pp_q[k] <= pp_d[k];
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [MAC_SUM_WIDTH-1:0] sum, prod, addend;
    logic [MAC_SUM_WIDTH-1:0] acc_d, acc_q;
    logic                     init_pending_d, init_pending_q;

    // Reduce partial products to group products, then load or accumulate per group.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NPP; k++) begin
            sum = sum + ({{(MAC_SUM_WIDTH-2*MAC_MIN_WIDTH){1'b0}}, pp_q[k]}
                         << (MAC_MIN_WIDTH * (k / MAC_LANES + k % MAC_LANES)));
        end
`ifdef MAC_CLUSTER_SIGNED_EN
        prod = group_add(sum, ~corr_q, mode_q, 1'b1);
`else
        prod = sum;
`endif
        if (!acc_en_q) begin
            addend = '0;
        end else if (init_pending_q) begin
            addend = init_q;
        end else begin
            addend = acc_q;
        end
        acc_d          = acc_q;
        init_pending_d = init_pending_q;
        if (valid_q) begin
            acc_d          = group_add(prod, addend, mode_q, 1'b0);
            init_pending_d = 1'b0;
        end
    end

    // Accumulator lanes and the post-reset init flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q          <= '0;
            init_pending_q <= 1'b1;
        end else if (en) begin
            acc_q          <= acc_d;
            init_pending_q <= init_pending_d;
        end
    end

    assign out0 = acc_q[0*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    assign out1 = acc_q[1*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    assign out2 = acc_q[2*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    assign out3 = acc_q[3*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];

endmodule

// File: tb/tb_mac_cluster.sv
// Directed self-checking bench for mac_cluster (default unsigned build).
module tb_mac_cluster;

    logic         clk;
    logic         rst;
    logic         en;
    logic [15:0]  A0, A1, A2, A3;
    logic [15:0]  B0, B1, B2, B3;
    logic [130:0] cfg;
    logic [31:0]  out0, out1, out2, out3;

    int checks;
    int failures;

    mac_cluster dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .A0   (A0),
        .A1   (A1),
        .A2   (A2),
        .A3   (A3),
        .B0   (B0),
        .B1   (B1),
        .B2   (B2),
        .B3   (B3),
        .cfg  (cfg),
        .out0 (out0),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [15:0] a3, a2, a1, a0, b3, b2, b1, b0);
        A3 = a3; A2 = a2; A1 = a1; A0 = a0;
        B3 = b3; B2 = b2; B1 = b1; B0 = b0;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic acc_en, input logic [31:0] init0);
        cfg = {32'd0, 32'd0, 32'd0, init0, acc_en, mode};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        set_ops(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        set_cfg(2'b00, 1'b0, 32'd0);
        step();
        step();
        checks++;
        if ({out3, out2, out1, out0} !== 128'd0) begin
            failures++;
            $display("FAIL reset_outs got=%h required=0", {out3, out2, out1, out0});
        end
        rst = 1'b0;
        $display("reset: outs=%h", {out3, out2, out1, out0});
    endtask

    task automatic test_single_load();
        set_cfg(2'b00, 1'b0, 32'd0);
        set_ops(16'hFFFF, 16'h0, 16'h0, 16'd3, 16'hFFFF, 16'h0, 16'h0, 16'd5);
        step();
        step();
        checks++;
        if (out0 !== 32'd15) begin
            failures++;
            $display("FAIL single_out0 got=%h required=%h", out0, 32'd15);
        end
        checks++;
        if (out3 !== 32'hFFFE0001) begin
            failures++;
            $display("FAIL single_out3 got=%h required=%h", out3, 32'hFFFE0001);
        end
        checks++;
        if ({out2, out1} !== 64'd0) begin
            failures++;
            $display("FAIL single_out21 got=%h required=0", {out2, out1});
        end
        $display("single load: outs=%h", {out3, out2, out1, out0});
    endtask

    task automatic test_dual_load();
        set_cfg(2'b01, 1'b0, 32'd0);
        // {A1,A0}=0x0001_0000 x {B1,B0}=0x0001_0000 ; {A3,A2}=0xFFFF x {B3,B2}=2
        set_ops(16'h0, 16'hFFFF, 16'h1, 16'h0, 16'h0, 16'h2, 16'h1, 16'h0);
        step();
        step();
        checks++;
        if ({out1, out0} !== 64'h00000001_00000000) begin
            failures++;
            $display("FAIL dual_grp0 got=%h required=%h", {out1, out0}, 64'h00000001_00000000);
        end
        checks++;
        if ({out3, out2} !== 64'h00000000_0001FFFE) begin
            failures++;
            $display("FAIL dual_grp1 got=%h required=%h", {out3, out2}, 64'h00000000_0001FFFE);
        end
        $display("dual load: outs=%h", {out3, out2, out1, out0});
    endtask

    task automatic test_quad_load();
        set_cfg(2'b10, 1'b0, 32'd0);
        set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        step();
        checks++;
        if ({out3, out2, out1, out0} !== 128'hFFFFFFFF_FFFFFFFE_00000000_00000001) begin
            failures++;
            $display("FAIL quad_load got=%h required=%h", {out3, out2, out1, out0},
                     128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
        end
        $display("quad load: outs=%h", {out3, out2, out1, out0});
    endtask

    task automatic test_reserved_mode();
        // Mode 11 acts as SINGLE: lanes stay independent.
        set_cfg(2'b11, 1'b0, 32'd0);
        set_ops(16'h0, 16'h0, 16'd4, 16'd2, 16'h0, 16'h0, 16'd5, 16'd3);
        step();
        step();
        checks++;
        if ({out1, out0} !== {32'd20, 32'd6}) begin
            failures++;
            $display("FAIL reserved_mode got=%h required=%h", {out1, out0}, {32'd20, 32'd6});
        end
        $display("reserved mode: outs=%h", {out3, out2, out1, out0});
    endtask

    task automatic test_single_accumulate();
        logic [31:0] exp0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_cfg(2'b00, 1'b1, 32'd100);
        set_ops(16'h0, 16'h0, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0, 16'd2);
        step();
        exp0 = 32'd100;
        for (int n = 0; n < 3; n++) begin
            step();
            exp0 = exp0 + 32'd2;
            checks++;
            if (out0 !== exp0) begin
                failures++;
                $display("FAIL acc_init_%0d got=%0d required=%0d", n, out0, exp0);
            end
            $display("accumulate %0d: out0=%0d", n, out0);
        end
        // Wrap within lane 0; carry must not leak into lane 1.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_cfg(2'b00, 1'b1, 32'd0);
        set_ops(16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF);
        step();
        step();
        checks++;
        if (out0 !== 32'hFFFE0001) begin
            failures++;
            $display("FAIL acc_wrap_first got=%h required=%h", out0, 32'hFFFE0001);
        end
        step();
        checks++;
        if ({out1, out0} !== {32'd0, 32'hFFFC0002}) begin
            failures++;
            $display("FAIL acc_wrap_second got=%h required=%h", {out1, out0}, {32'd0, 32'hFFFC0002});
        end
        $display("accumulate wrap: out1=%h out0=%h", out1, out0);
    endtask

    task automatic test_dual_carry();
        // Load group0 = 0xFFFFFFFF (0xFFFF * 0x10001), group1 = 35.
        set_cfg(2'b01, 1'b0, 32'd0);
        set_ops(16'h0, 16'd5, 16'h0, 16'hFFFF, 16'h0, 16'd7, 16'h1, 16'h1);
        step();
        // Accumulate product 1 into group0, 0 into group1.
        set_cfg(2'b01, 1'b1, 32'd0);
        set_ops(16'h0, 16'h0, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0, 16'd1);
        step();
        checks++;
        if ({out3, out2, out1, out0} !== {32'd0, 32'd35, 32'd0, 32'hFFFFFFFF}) begin
            failures++;
            $display("FAIL dual_carry_load got=%h required=%h", {out3, out2, out1, out0},
                     {32'd0, 32'd35, 32'd0, 32'hFFFFFFFF});
        end
        step();
        checks++;
        if ({out3, out2, out1, out0} !== {32'd0, 32'd35, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL dual_carry_acc got=%h required=%h", {out3, out2, out1, out0},
                     {32'd0, 32'd35, 32'd1, 32'd0});
        end
        $display("dual carry: outs=%h", {out3, out2, out1, out0});
    endtask

    task automatic test_reset_mid_stream();
        set_cfg(2'b00, 1'b1, 32'd100);
        set_ops(16'h0, 16'h0, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0, 16'd2);
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({out3, out2, out1, out0} !== 128'd0) begin
            failures++;
            $display("FAIL mid_reset_clear got=%h required=0", {out3, out2, out1, out0});
        end
        rst = 1'b0;
        step();
        step();
        checks++;
        if (out0 !== 32'd102) begin
            failures++;
            $display("FAIL mid_reset_restart got=%0d required=102", out0);
        end
        en = 1'b0;
        step();
        step();
        checks++;
        if (out0 !== 32'd102) begin
            failures++;
            $display("FAIL en_hold got=%0d required=102", out0);
        end
        en = 1'b1;
        step();
        checks++;
        if (out0 !== 32'd104) begin
            failures++;
            $display("FAIL en_resume got=%0d required=104", out0);
        end
        $display("reset mid-stream / hold: out0=%0d", out0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        cfg      = '0;
        set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_single_load();
        test_dual_load();
        test_quad_load();
        test_reserved_mode();
        test_single_accumulate();
        test_dual_carry();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
